// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write port and
// synchronous read port with enable. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable latency, byte-enable
// writes and bad-address error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;
    logic              load_ok;
    logic              err;
    logic              accept;
    logic              done;
    logic [DATA_W-1:0] arr_rdata;

    assign err = (addr_q[1:0] != 2'b00)
              || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign accept = (state == IDLE) && req_valid;
    assign done   = (state == WAIT) && (cnt == '0);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = load_ok ? arr_rdata : '0;

    // The counter spans the whole latency, so even WAIT_CYCLES=0 spends
    // one cycle here while the latched address settles into err.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            load_ok <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (done) begin
                err_q   <= err;
                load_ok <= !wr_q && !err;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (done && wr_q && !err),
        .be    (be_q),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .re    (done && !wr_q && !err),
        .raddr (addr_q[AW+1:2]),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: u_w2 runs WAIT_CYCLES=2, u_w0 runs WAIT_CYCLES=0.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  rsp_err;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic [3:0]  req_be    [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [2][DEPTH];
    int          cyc = 0;
    int          last_acc [2] = '{0, 0};
    int          passed = 0;
    int          total = 0;
    int          failed = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int s = 0; s < 2; s++) begin
            if (req_valid[s] && req_ready[s]) last_acc[s] <= cyc + 1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic send(int s, logic w, logic [31:0] a, logic [31:0] d,
                        logic [3:0] be, logic bad, output int acc);
        exp_t       e;
        int         n = 0;
        logic [7:0] idx;
        idx     = a[9:2];
        e.rdata = '0;
        e.err   = bad;
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.rdata = model[s][idx];
            end
        end
        exp_q.push_back(e);
        req_write[s] = w;
        req_addr[s]  = a;
        req_wdata[s] = d;
        req_be[s]    = be;
        req_valid[s] = 1'b1;
        while (!req_ready[s] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        acc = last_acc[s];
        chk("accept", last_acc[s], cyc);
    endtask

    task automatic recv(int s, int acc, int hold);
        int   n = 0;
        exp_t e;
        while (!rsp_valid[s] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_valid", 32'(rsp_valid[s]), 1);
        chk("latency", cyc - acc, (s == 0) ? 3 : 1);
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
            e.rdata = '0;
            e.err   = 1'b0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("rdata", rsp_rdata[s], e.rdata);
        chk("err", 32'(rsp_err[s]), 32'(e.err));
        if (hold > 0) begin
            req_write[s] = 1'b0;
            req_addr[s]  = 32'h10;
            req_valid[s] = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(rsp_valid[s]), 1);
                chk("hold_rdata", rsp_rdata[s], e.rdata);
                chk("hold_err", 32'(rsp_err[s]), 32'(e.err));
                chk("hold_ready", 32'(req_ready[s]), 0);
            end
            chk("no_accept", last_acc[s], acc);
            req_valid[s] = 1'b0;
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        if (s == 0) rsp_ready[0] = 1'b0;
        chk("rsp_drop", 32'(rsp_valid[s]), 0);
    endtask

    task automatic xact(int s, logic w, logic [31:0] a, logic [31:0] d,
                        logic [3:0] be, logic bad, int hold,
                        output int acc);
        send(s, w, a, d, be, bad, acc);
        recv(s, acc, hold);
    endtask

    initial begin
        int   acc;
        int   prev;
        logic seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        rsp_ready = 2'b10;
        for (int s = 0; s < 2; s++) begin
            req_addr[s]  = '0;
            req_wdata[s] = '0;
            req_be[s]    = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready", 32'(req_ready[s]), 1);
            chk("rst_rsp_valid", 32'(rsp_valid[s]), 0);
            chk("rst_rdata", rsp_rdata[s], 0);
            chk("rst_err", 32'(rsp_err[s]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, acc);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0, 0, acc);
        chk("load_10", model[0][4], 32'hDEADBEEF);

        xact(0, 1, 32'h20, 32'h11223344, 4'hF, 0, 0, acc);
        xact(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, acc);
        xact(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, acc);
        chk("be_merge", model[0][8], 32'h11BB33DD);
        xact(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, acc);
        xact(0, 0, 32'h20, 32'h0, 4'hF, 0, 0, acc);

        xact(0, 1, 32'h22, 32'h55555555, 4'hF, 1, 0, acc);
        xact(0, 0, DEPTH * 4, 32'h0, 4'h0, 1, 0, acc);
        xact(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, acc);

        xact(0, 1, DEPTH * 4 - 4, 32'h0BADF00D, 4'hF, 0, 0, acc);
        xact(0, 0, DEPTH * 4 - 4, 32'h0, 4'h0, 0, 0, acc);

        xact(0, 0, 32'h20, 32'h0, 4'h0, 0, 5, acc);

        xact(1, 1, 32'h40, 32'h01020304, 4'hF, 0, 0, acc);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            xact(1, 0, 32'h40, 32'h0, 4'h0, 0, 0, acc);
            if (k > 0) chk("b2b_spacing", acc - prev, 3);
            prev = acc;
        end

        xact(0, 1, 32'h30, 32'h0, 4'hF, 0, 0, acc);
        send(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 0, acc);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        model[0][12] = 32'h0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen), 0);
        chk("abort_ready", 32'(req_ready[0]), 1);
        xact(0, 0, 32'h30, 32'h0, 4'h0, 0, 0, acc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
